// File: rtl/bram_port_arb.sv
// Two-requester round-robin arbiter for a single-port BRAM.
// Write and read requesters share one port; read data returns RD_LAT+1 cycles after the read ack.
module bram_port_arb #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_ena,
  output logic              o_wea,
  output logic [ADDR_W-1:0] o_addra,
  output logic [DATA_W-1:0] o_dina,
  input  logic [DATA_W-1:0] i_douta
);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

  gnt_e              gnt;
  logic              last_rd;
  logic              last_rd_nxt;
  logic              wr_elig;
  logic              rd_elig;
  logic              ena_nxt;
  logic              wea_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [RD_LAT-1:0] rd_pipe;

  // Grant decision: a requester acked this cycle sits out the next edge.
  always_comb begin
    gnt         = GNT_IDLE;
    last_rd_nxt = last_rd;
    ena_nxt     = 1'b0;
    wea_nxt     = 1'b0;
    addr_nxt    = '0;
    data_nxt    = '0;
    wr_elig     = i_wr_req & ~o_wr_ack;
    rd_elig     = i_rd_req & ~o_rd_ack;

    if (wr_elig && rd_elig) begin
      gnt = last_rd ? GNT_WR : GNT_RD;
    end else if (wr_elig) begin
      gnt = GNT_WR;
    end else if (rd_elig) begin
      gnt = GNT_RD;
    end

    case (gnt)
      GNT_WR: begin
        ena_nxt     = 1'b1;
        wea_nxt     = 1'b1;
        addr_nxt    = i_wr_addr;
        data_nxt    = i_wr_data;
        last_rd_nxt = 1'b0;
      end
      GNT_RD: begin
        ena_nxt     = 1'b1;
        addr_nxt    = i_rd_addr;
        last_rd_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Command register, round-robin pointer and read-return pipeline.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      last_rd    <= 1'b1;
      o_ena      <= 1'b0;
      o_wea      <= 1'b0;
      o_addra    <= '0;
      o_dina     <= '0;
      o_wr_ack   <= 1'b0;
      o_rd_ack   <= 1'b0;
      rd_pipe    <= '0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      last_rd    <= last_rd_nxt;
      o_ena      <= ena_nxt;
      o_wea      <= wea_nxt;
      o_addra    <= addr_nxt;
      o_dina     <= data_nxt;
      o_wr_ack   <= (gnt == GNT_WR);
      o_rd_ack   <= (gnt == GNT_RD);
      // Bit k is high RD_LAT-1-k... i.e. the top bit marks the cycle i_douta is valid.
      rd_pipe    <= RD_LAT'({rd_pipe, o_rd_ack});
      o_rd_valid <= rd_pipe[RD_LAT-1];
      if (rd_pipe[RD_LAT-1]) begin
        o_rd_data <= i_douta;
      end
    end
  end

endmodule

// File: tb/tb_bram_port_arb.sv
// Bench for bram_port_arb: two instances (read latency 1 and 2) on shared requests,
// each with a behavioural BRAM; read returns checked against a scoreboard.
module tb_bram_port_arb;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;

  logic          wr_ack1, rd_ack1, rd_valid1, ena1, wea1;
  logic [AW-1:0] addra1;
  logic [DW-1:0] rd_data1, dina1, douta1;
  logic          wr_ack2, rd_ack2, rd_valid2, ena2, wea2;
  logic [AW-1:0] addra2;
  logic [DW-1:0] rd_data2, dina2, douta2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  int            lat1[$];
  int            lat2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_port_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack1),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(rd_ack1),
    .o_rd_valid(rd_valid1), .o_rd_data(rd_data1),
    .o_ena(ena1), .o_wea(wea1), .o_addra(addra1), .o_dina(dina1), .i_douta(douta1)
  );

  bram_port_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut2 (
    .i_clk(clk), .i_reset(rst),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack2),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(rd_ack2),
    .o_rd_valid(rd_valid2), .o_rd_data(rd_data2),
    .o_ena(ena2), .o_wea(wea2), .o_addra(addra2), .o_dina(dina2), .i_douta(douta2)
  );

  // Behavioural BRAMs: write commits at the edge, read output registered 1 or 2 times.
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] mem2 [0:(1<<AW)-1];
  logic [DW-1:0] rq1, rq2a, rq2b;

  always @(posedge clk) begin
    if (ena1 && wea1) mem1[addra1] <= dina1;
    if (ena1 && !wea1) rq1 <= mem1[addra1];
    if (ena2 && wea2) mem2[addra2] <= dina2;
    if (ena2 && !wea2) rq2a <= mem2[addra2];
    rq2b <= rq2a;
  end
  assign douta1 = rq1;
  assign douta2 = rq2b;

  // Read-return monitors: data from the scoreboard, cycle from ack + latency + 1.
  always @(negedge clk) begin
    if (rd_ack1 === 1'b1) lat1.push_back(cyc + 2);
    if (rd_ack2 === 1'b1) lat2.push_back(cyc + 3);
    if (rd_valid1 === 1'b1) begin
      vectors++;
      if (q1.size() == 0 || lat1.size() == 0) begin
        miscompares++;
        $display("FAIL rd_valid_lat1 unexpected valid at cycle %0d data=%h", cyc, rd_data1);
      end else begin
        logic [DW-1:0] e;
        int            ec;
        e  = q1.pop_front();
        ec = lat1.pop_front();
        if (rd_data1 !== e || cyc != ec) begin
          miscompares++;
          $display("FAIL rd_return_lat1 got data=%h cycle=%0d, required data=%h cycle=%0d",
                   rd_data1, cyc, e, ec);
        end
      end
    end
    if (rd_valid2 === 1'b1) begin
      vectors++;
      if (q2.size() == 0 || lat2.size() == 0) begin
        miscompares++;
        $display("FAIL rd_valid_lat2 unexpected valid at cycle %0d data=%h", cyc, rd_data2);
      end else begin
        logic [DW-1:0] e;
        int            ec;
        e  = q2.pop_front();
        ec = lat2.pop_front();
        if (rd_data2 !== e || cyc != ec) begin
          miscompares++;
          $display("FAIL rd_return_lat2 got data=%h cycle=%0d, required data=%h cycle=%0d",
                   rd_data2, cyc, e, ec);
        end
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (wr_ack1 === 1'b1) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL write_ack addr=%0d got no ack, required ack within 20 cycles", a);
    end else if ({rd_ack1, ena1, wea1, addra1, dina1} !== {1'b0, 1'b1, 1'b1, a, d}) begin
      miscompares++;
      $display("FAIL write_bus got rd_ack=%b ena=%b wea=%b addr=%0d din=%h, required 0 1 1 %0d %h",
               rd_ack1, ena1, wea1, addra1, dina1, a, d);
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = a;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rd_ack1 === 1'b1) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL read_ack addr=%0d got no ack, required ack within 20 cycles", a);
    end else begin
      q1.push_back(exp_d);
      q2.push_back(exp_d);
      if ({wr_ack1, ena1, wea1, addra1, dina1} !== {1'b0, 1'b1, 1'b0, a, {DW{1'b0}}}) begin
        miscompares++;
        $display("FAIL read_bus got wr_ack=%b ena=%b wea=%b addr=%0d din=%h, required 0 1 0 %0d 0",
                 wr_ack1, ena1, wea1, addra1, dina1, a);
      end
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    vectors++;
    if (q1.size() != 0 || q2.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d/%0d reads outstanding, required 0/0", q1.size(), q2.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wr_req = 1'b1; wr_addr = AW'(100); wr_data = 32'hCAFE_0001;
    rd_req = 1'b1; rd_addr = AW'(100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({wr_ack1, rd_ack1, rd_valid1, rd_data1, ena1, wea1, addra1, dina1,
           wr_ack2, rd_ack2, rd_valid2, rd_data2, ena2, wea2, addra2, dina2} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d got ena=%b wea=%b acks=%b%b valid=%b, required all 0",
                 i, ena1, wea1, wr_ack1, rd_ack1, rd_valid1);
      end
    end
  endtask

  // Both requests held from reset: strict W,R,W,R alternation, one ack per cycle.
  task automatic test_contention();
    logic          exp_w;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      exp_w = (i % 2 == 0);
      ea    = AW'(100);
      ed    = exp_w ? 32'hCAFE_0001 : 32'h0;
      vectors++;
      if ({wr_ack1, rd_ack1, ena1, wea1, addra1, dina1} !== {exp_w, ~exp_w, 1'b1, exp_w, ea, ed}) begin
        miscompares++;
        $display("FAIL contention cycle %0d got acks=%b%b ena=%b wea=%b addr=%0d din=%h, required %b%b 1 %b %0d %h",
                 i, wr_ack1, rd_ack1, ena1, wea1, addra1, dina1, exp_w, ~exp_w, exp_w, ea, ed);
      end
      if (rd_ack1 === 1'b1) begin
        q1.push_back(32'hCAFE_0001);
        q2.push_back(32'hCAFE_0001);
      end
    end
    @(posedge clk); #1;
    wr_req = 1'b0; rd_req = 1'b0;
    wait_drain();
  endtask

  task automatic test_write();
    do_write(AW'(5), 32'h3);
    @(negedge clk);
    vectors++;
    if ({wr_ack1, rd_ack1, ena1, wea1, addra1, dina1} !== '0) begin
      miscompares++;
      $display("FAIL write_then_idle got acks=%b%b ena=%b wea=%b addr=%0d din=%h, required all 0",
               wr_ack1, rd_ack1, ena1, wea1, addra1, dina1);
    end
  endtask

  task automatic test_read();
    do_read(AW'(5), 32'h3);
    wait_drain();
  endtask

  task automatic test_boundary();
    logic got;
    do_write(AW'(8191), 32'hA);
    do_read(AW'(8191), 32'hA);
    wait_drain();
    do_write(AW'(0), 32'h1111_1111);
    do_read(AW'(0), 32'h1111_1111);
    wait_drain();
    // Read right behind a write to the same address must see the new word.
    got = 1'b0;
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = AW'(0); wr_data = 32'h0BAD_F00D;
    rd_req = 1'b1; rd_addr = AW'(0);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (wr_ack1 === 1'b1 || rd_ack1 === 1'b1) got = 1'b1;
    end
    vectors++;
    if ({wr_ack1, rd_ack1} !== 2'b10) begin
      miscompares++;
      $display("FAIL hazard_first_grant got acks=%b%b, required 10", wr_ack1, rd_ack1);
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({wr_ack1, rd_ack1, ena1, wea1, addra1} !== {1'b0, 1'b1, 1'b1, 1'b0, AW'(0)}) begin
      miscompares++;
      $display("FAIL hazard_second_grant got acks=%b%b ena=%b wea=%b addr=%0d, required 01 1 0 0",
               wr_ack1, rd_ack1, ena1, wea1, addra1);
    end
    if (rd_ack1 === 1'b1) begin
      q1.push_back(32'h0BAD_F00D);
      q2.push_back(32'h0BAD_F00D);
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid_read();
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = AW'(5);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rd_ack1 === 1'b1) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL midreset_ack got no read ack, required ack within 20 cycles");
    end
    @(posedge clk); #1;
    rd_req = 1'b0; rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if ({rd_valid1, rd_valid2, rd_ack1, wr_ack1} !== 4'b0) begin
        miscompares++;
        $display("FAIL midreset_quiet cycle %0d got valid=%b%b acks=%b%b, required 0000",
                 i, rd_valid1, rd_valid2, rd_ack1, wr_ack1);
      end
      if (i == 1) begin
        @(posedge clk); #1;
        rst = 1'b1;
      end
    end
    lat1.delete();
    lat2.delete();
    do_write(AW'(5), 32'h55);
    do_read(AW'(5), 32'h55);
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no finish, required finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_contention();
    test_write();
    test_read();
    test_boundary();
    test_reset_mid_read();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
